regfile_dump_reader: RTL and testbench

//   Read-side sequencer for the processor register file: walks a window of

---
 rtl/regfile_dump_reader.sv | 103 ++++++++++
 tb/tb_regfile_dump_reader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Register-file dump sequencer: walks a window of registers and streams each word over valid/ready.
// Optional running checksum output enabled by defining RFDUMP_CHECKSUM_EN.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
`ifdef RFDUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              load;
  logic              accept;

  // A zero or oversized request means a full dump of every register.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
    if ((c == '0) || (c > FULL_CNT)) return FULL_CNT;
    return c;
  endfunction

  assign load    = (state == RUN) && (!out_valid || out_ready);
  assign accept  = out_valid && out_ready;
  assign rd_addr = (state == RUN) ? ptr : '0;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr       <= first_addr;
            remaining <= clamp_count(count);
            state     <= RUN;
          end
        end
        RUN: begin
          // Output register refills whenever empty or being drained this cycle.
          if (load) begin
            out_data  <= rd_data;
            out_addr  <= ptr;
            out_valid <= 1'b1;
            ptr       <= ptr + 1'b1;
            remaining <= remaining - ONE_CNT;
            if (remaining == ONE_CNT) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (accept) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RFDUMP_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + out_data;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed self-checking bench for regfile_dump_reader against a simple register-file model.
module tb_regfile_dump_reader;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;
`ifdef RFDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  logic [DATA_W-1:0] regs [NUM_REGS];
  int checks = 0;
  int errors = 0;

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  regfile_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .first_addr(first_addr), .count(count),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done)
`ifdef RFDUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns one falling edge after start was sampled.
  task automatic start_dump(input logic [ADDR_W-1:0] f, input logic [ADDR_W:0] c);
    start = 1'b1; first_addr = f; count = c;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_no_valid", out_valid, 0);
  endtask

  task automatic expect_words(input int f, input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a = (f + i) % NUM_REGS;
      check("word_valid", out_valid, 1);
      check("word_addr", out_addr, a);
      check("word_data", out_data, 32'h1000 + a);
    end
  endtask

  task automatic expect_done();
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_valid_low", out_valid, 0);
    check("done_idle", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h1000 + i;
    reset = 1'b1; start = 1'b0; first_addr = '0; count = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", out_addr, 0);
    check("rst_rd_addr", rd_addr, 0);

    // Basic four-word dump
    start_dump(5'd0, 6'd4);
    expect_words(0, 4);
    expect_done();
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // Wrap past the top register
    start_dump(5'd30, 6'd4);
    expect_words(30, 4);
    expect_done();
    @(negedge clk);

    // Backpressure on the second word
    start_dump(5'd8, 6'd4);
    expect_words(8, 2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_addr_hold", out_addr, 9);
      check("bp_data_hold", out_data, 32'h1009);
    end
    out_ready = 1'b1;
    expect_words(10, 2);
    expect_done();
    @(negedge clk);

    // Full dump via count=0, stray start mid-stream, start on done
    start_dump(5'd0, 6'd0);
    for (int i = 0; i < NUM_REGS; i++) begin
      @(negedge clk);
      check("full_addr", out_addr, i);
      check("full_data", out_data, 32'h1000 + i);
      if (i == 10) begin start = 1'b1; first_addr = 5'd20; count = 6'd1; end
      else start = 1'b0;
    end
    @(negedge clk);
    check("full_done", done, 1);
    check("full_valid_low", out_valid, 0);
    start_dump(5'd3, 6'd2);
    check("restart_done_low", done, 0);
    expect_words(3, 2);
    expect_done();
    @(negedge clk);

    // Reset mid-stream abandons the dump
    start_dump(5'd0, 6'd8);
    expect_words(0, 5);
    reset = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_no_done", done, 0);
    start_dump(5'd0, 6'd2);
    expect_words(0, 2);
    expect_done();
    @(negedge clk);
    check("after_two_idle", out_valid, 0);

`ifdef RFDUMP_CHECKSUM_EN
    regs[0] = 32'h1; regs[1] = 32'h2; regs[2] = 32'h3; regs[3] = 32'hFFFF_FFFF;
    start = 1'b1; first_addr = 5'd0; count = 6'd4;
    @(negedge clk);
    start = 1'b0;
    check("cks_cleared", checksum, 0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    @(negedge clk);
    check("cks_done", done, 1);
    check("cks_value", checksum, 32'h0000_0005);
    @(negedge clk);
    check("cks_stable", checksum, 32'h0000_0005);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
